// File: rtl/aes_block_loader.sv
// -----------------------------------------------------------------------------
// aes_block_loader
//
// Upstream feeder for an AES encryption core. It assembles a 256-bit key and
// a 128-bit plaintext block from a 32-bit host word stream with a valid/ready
// handshake. The assembled block is held steady on its outputs until the
// downstream capture logic takes it. The last complete key is kept, so that
// later blocks can be sent as plaintext only. A zeroize input clears the
// stored key at once.
//
// The first word of every group is the most significant one. This matches
// big-endian hex notation (key[255:224] first, plaintext[127:96] first).
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     host word valid
//   in_ready     loader accepts a word this cycle
//   in_data      host word (32 bits)
//   in_key_sel   looked at only on the first word of a transaction:
//                1 = 8 key words then 4 plaintext words,
//                0 = reuse the stored key, 4 plaintext words
//   key_zeroize  clear the stored key and abort any transaction
//   out_valid    plaintext/key stable and valid
//   out_ready    downstream accepts the block
//   plaintext    assembled plaintext (128 bits, registered)
//   key          assembled key (256 bits, registered)
//   key_loaded   a complete key is stored
//   err          sticky: plaintext submitted without a stored key
//   blk_count    blocks handed off (CNT_W bits, wraps)
// -----------------------------------------------------------------------------
module aes_block_loader #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_key_sel,
    input  logic              key_zeroize,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      plaintext,
    output logic [255:0]      key,
    output logic              key_loaded,
    output logic              err,
    output logic [CNT_W-1:0]  blk_count
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_KEY = 3'd1,
        ST_LOAD_PT  = 3'd2,
        ST_DROP     = 3'd3,
        ST_PRESENT  = 3'd4
    } state_t;

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [127:0]       plaintext_q;
    logic [255:0]       key_q;
    logic               key_loaded_q;
    logic               err_q;
    logic [CNT_W-1:0]   blk_count_q;

    logic               word_acc_s;
    logic [7:0]         key_hi_s;
    logic [6:0]         pt_hi_s;

    // A word is taken only when the host offers it and the registered ready is high.
    assign word_acc_s = in_valid & in_ready_q;

    // The word index selects the slice, counted from the MSB down.
    assign key_hi_s = 8'd255 - {cnt_q, 5'd0};
    assign pt_hi_s  = 7'd127 - {cnt_q[1:0], 5'd0};

    // Loader state machine. It also holds every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            plaintext_q  <= 128'd0;
            key_q        <= 256'd0;
            key_loaded_q <= 1'b0;
            err_q        <= 1'b0;
            blk_count_q  <= {CNT_W{1'b0}};
        end else if (key_zeroize) begin
            // Zeroize overrides everything except reset. A word offered in
            // this cycle is consumed, because ready stays as it is, but it is
            // not stored. err and blk_count keep their values.
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            plaintext_q  <= 128'd0;
            key_q        <= 256'd0;
            key_loaded_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (word_acc_s) begin
                        cnt_q <= 3'd1;
                        if (in_key_sel) begin
                            // Starting a new key makes the old key invalid,
                            // even if the host later gives up half way.
                            key_q[255:224] <= in_data;
                            key_loaded_q   <= 1'b0;
                            state_q        <= ST_LOAD_KEY;
                        end else if (key_loaded_q) begin
                            plaintext_q[127:96] <= in_data;
                            state_q             <= ST_LOAD_PT;
                        end else begin
                            // No usable key: flag it and throw away the block.
                            err_q   <= 1'b1;
                            state_q <= ST_DROP;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_LOAD_KEY: begin
                    if (word_acc_s) begin
                        key_q[key_hi_s -: 32] <= in_data;
                        if (cnt_q == 3'd7) begin
                            key_loaded_q <= 1'b1;
                            cnt_q        <= 3'd0;
                            state_q      <= ST_LOAD_PT;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end else begin
                        state_q <= ST_LOAD_KEY;
                    end
                end

                ST_LOAD_PT: begin
                    if (word_acc_s) begin
                        plaintext_q[pt_hi_s -: 32] <= in_data;
                        if (cnt_q == 3'd3) begin
                            // Ready drops and valid rises together, so the
                            // host cannot slip a word into the presented block.
                            cnt_q       <= 3'd0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_PRESENT;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end else begin
                        state_q <= ST_LOAD_PT;
                    end
                end

                ST_DROP: begin
                    if (word_acc_s) begin
                        if (cnt_q == 3'd3) begin
                            cnt_q   <= 3'd0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end else begin
                        state_q <= ST_DROP;
                    end
                end

                ST_PRESENT: begin
                    if (out_ready) begin
                        // Ready comes back one cycle after the handoff, so
                        // the next first word lands in IDLE.
                        blk_count_q <= blk_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_PRESENT;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= 3'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign plaintext  = plaintext_q;
    assign key        = key_q;
    assign key_loaded = key_loaded_q;
    assign err        = err_q;
    assign blk_count  = blk_count_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// -----------------------------------------------------------------------------
// tb_aes_block_loader
//
// Drives host word transactions into aes_block_loader. For every block that
// should be presented, the expected key and plaintext are queued. They are
// compared when the loader presents that block. Inputs change on the falling
// edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_aes_block_loader;

    localparam int CNT_W = 16;
    localparam int BOUND = 50;

    localparam logic [255:0] K1  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2 = 128'hffeeddccbbaa99887766554433221100;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              in_key_sel;
    logic              key_zeroize;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      plaintext;
    logic [255:0]      key;
    logic              key_loaded;
    logic              err;
    logic [CNT_W-1:0]  blk_count;

    typedef struct packed {
        logic [255:0] k;
        logic [127:0] p;
    } blk_t;

    blk_t sb_q[$];
    int   n_checks;
    int   n_fail;

    aes_block_loader #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_key_sel  (in_key_sel),
        .key_zeroize (key_zeroize),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .plaintext   (plaintext),
        .key         (key),
        .key_loaded  (key_loaded),
        .err         (err),
        .blk_count   (blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one word; return at the falling edge after it was accepted.
    task automatic send_word(input logic [31:0] d, input logic sel);
        int n;
        n = 0;
        in_valid   = 1'b1;
        in_data    = d;
        in_key_sel = sel;
        while (!in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) chk("send_timeout", 256'd1, 256'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_block(input logic [255:0] k, input logic [127:0] p,
                              input logic sel, input logic stall, input logic push);
        blk_t e;
        if (push) begin
            e.k = k;
            e.p = p;
            sb_q.push_back(e);
        end
        if (sel) begin
            for (int i = 0; i < 8; i++) begin
                if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
                send_word(k[255 - 32*i -: 32], (i == 0) ? 1'b1 : 1'b0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
            // The key select is driven to 1 on later words; the loader must ignore it.
            send_word(p[127 - 32*i -: 32], (!sel && i == 0) ? 1'b0 : 1'b1);
        end
    endtask

    task automatic handoff(input string tag);
        int   n;
        blk_t e;
        n = 0;
        while (!out_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {255'd0, out_valid}, 256'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_key"}, key, e.k);
            chk({tag, "_pt"}, {128'd0, plaintext}, {128'd0, e.p});
        end else begin
            chk({tag, "_sb_underflow"}, 256'd1, 256'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {255'd0, out_valid}, 256'd0);
        chk({tag, "_ready_back"}, {255'd0, in_ready}, 256'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},   {255'd0, in_ready},   256'd1);
        chk({tag, "_out_valid"},  {255'd0, out_valid},  256'd0);
        chk({tag, "_pt"},         {128'd0, plaintext},  256'd0);
        chk({tag, "_key"},        key,                  256'd0);
        chk({tag, "_key_loaded"}, {255'd0, key_loaded}, 256'd0);
        chk({tag, "_err"},        {255'd0, err},        256'd0);
        chk({tag, "_blk"},        {240'd0, blk_count},  256'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [255:0] k_hold;
        logic [127:0] p_hold;
        n_checks    = 0;
        n_fail      = 0;
        in_valid    = 1'b0;
        in_data     = 32'd0;
        in_key_sel  = 1'b0;
        key_zeroize = 1'b0;
        out_ready   = 1'b0;
        @(negedge clk);
        do_reset();
        chk_reset_vals("reset");

        // No key stored: the block is consumed, err is set, nothing is presented.
        load_block(256'd0, PT1, 1'b0, 1'b0, 1'b0);
        chk("nokey_err", {255'd0, err}, 256'd1);
        chk("nokey_ready", {255'd0, in_ready}, 256'd1);
        repeat (3) @(negedge clk);
        chk("nokey_no_valid", {255'd0, out_valid}, 256'd0);
        chk("nokey_blk", {240'd0, blk_count}, 256'd0);

        // Full load: out_valid must already be high one cycle after the 12th accept.
        load_block(K1, PT1, 1'b1, 1'b0, 1'b1);
        chk("full_valid_lat", {255'd0, out_valid}, 256'd1);
        chk("full_key_loaded", {255'd0, key_loaded}, 256'd1);
        handoff("full");
        chk("full_blk", {240'd0, blk_count}, 256'd1);

        // Key reuse with the stored key.
        load_block(K1, PT2, 1'b0, 1'b0, 1'b1);
        handoff("reuse");
        chk("reuse_blk", {240'd0, blk_count}, 256'd2);

        // Backpressure: a word waits while the block is held for 10 cycles.
        load_block(K1, PT1, 1'b1, 1'b0, 1'b1);
        begin
            blk_t e;
            e.k = K1;
            e.p = PT2;
            sb_q.push_back(e);
        end
        k_hold     = key;
        p_hold     = plaintext;
        in_valid   = 1'b1;
        in_data    = PT2[127:96];
        in_key_sel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_ready_low", {255'd0, in_ready}, 256'd0);
            chk("bp_valid_high", {255'd0, out_valid}, 256'd1);
            chk("bp_key_stable", key, k_hold);
            chk("bp_pt_stable", {128'd0, plaintext}, {128'd0, p_hold});
        end
        handoff("bp1");
        chk("bp1_blk", {240'd0, blk_count}, 256'd3);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) send_word(PT2[127 - 32*i -: 32], 1'b1);
        handoff("bp2");
        chk("bp2_blk", {240'd0, blk_count}, 256'd4);

        // Random stalls during a full load must give the same outputs.
        load_block(K1, PT1, 1'b1, 1'b1, 1'b1);
        handoff("stall");
        chk("stall_blk", {240'd0, blk_count}, 256'd5);
        chk("err_sticky", {255'd0, err}, 256'd1);

        // Reset while a block is being presented.
        load_block(K1, PT2, 1'b1, 1'b0, 1'b0);
        chk("pres_valid", {255'd0, out_valid}, 256'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_pres");
        rst = 1'b0;

        // Zeroize part way through a new key.
        load_block(K1, PT1, 1'b1, 1'b0, 1'b1);
        handoff("pre_zero");
        for (int i = 0; i < 5; i++) send_word(PT2[127 - 32*(i % 4) -: 32], (i == 0) ? 1'b1 : 1'b0);
        chk("partial_key_loaded", {255'd0, key_loaded}, 256'd0);
        key_zeroize = 1'b1;
        in_valid    = 1'b1;
        in_data     = 32'hdeadbeef;
        @(negedge clk);
        key_zeroize = 1'b0;
        in_valid    = 1'b0;
        chk("zero_key", key, 256'd0);
        chk("zero_key_loaded", {255'd0, key_loaded}, 256'd0);
        chk("zero_pt", {128'd0, plaintext}, 256'd0);
        chk("zero_valid", {255'd0, out_valid}, 256'd0);
        chk("zero_ready", {255'd0, in_ready}, 256'd1);
        chk("zero_err_kept", {255'd0, err}, 256'd0);
        chk("zero_blk_kept", {240'd0, blk_count}, 256'd1);
        load_block(256'd0, PT1, 1'b0, 1'b0, 1'b0);
        chk("zero_then_err", {255'd0, err}, 256'd1);
        repeat (3) @(negedge clk);
        chk("zero_no_valid", {255'd0, out_valid}, 256'd0);
        chk("sb_empty", sb_q.size(), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
